// File: rtl/ofdm_rx_deserializer.sv
// ---------------------------------------------------------------------------
// ofdm_rx_deserializer
//   Receive-side deserialiser for the OFDM chain. It hunts for SYNC_LEN
//   consecutive SYNC_WORD symbols. Once locked, it frames the next FRAME_LEN
//   symbols into a symbol FIFO. A shift register then re-serialises the FIFO
//   contents LSB-first as a gapless bit stream.
//
// Ports
//   clk        : rising-edge clock
//   reset      : synchronous active-high reset (clears every output and state)
//   sym_in     : received SYM_W-bit symbol
//   sym_valid  : sym_in valid; with sym_valid=0 the framing FSM holds
//   x_out      : recovered serial bit (registered)
//   x_valid    : x_out valid this cycle
//   x_sof      : marks bit0 of the first symbol of each frame
//   locked     : high while the framer is in its DATA state
//   overflow   : sticky flag, a data symbol was dropped on a full FIFO
//   fifo_level : FIFO occupancy after the previous edge
// ---------------------------------------------------------------------------
module ofdm_rx_deserializer #(
  parameter int                SYM_W      = 4,
  parameter logic [SYM_W-1:0]  SYNC_WORD  = 4'b0110,
  parameter int                SYNC_LEN   = 2,
  parameter int                FRAME_LEN  = 8,
  parameter int                FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [SYM_W-1:0]              sym_in,
  input  logic                          sym_valid,
  output logic                          x_out,
  output logic                          x_valid,
  output logic                          x_sof,
  output logic                          locked,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int SC_W = $clog2(SYNC_LEN + 1);
  localparam int FC_W = $clog2(FRAME_LEN + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int BC_W = $clog2(SYM_W + 1);

  localparam logic [SC_W-1:0] SYNC_LAST  = SC_W'(SYNC_LEN - 1);
  localparam logic [FC_W-1:0] FRAME_LAST = FC_W'(FRAME_LEN - 1);
  localparam logic [LW-1:0]   LVL_FULL   = LW'(FIFO_DEPTH);
  localparam logic [BC_W-1:0] BITS_FULL  = BC_W'(SYM_W);
  localparam logic [BC_W-1:0] BITS_ONE   = BC_W'(1);

  typedef enum logic {HUNT, DATA} state_t;

  state_t            state_q, state_d;
  logic [SC_W-1:0]   sync_cnt_q, sync_cnt_d;
  logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic              locked_q, locked_d;

  // FIFO storage holds {sof_tag, symbol}; occupancy is tracked by level_q.
  logic [SYM_W:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              ovf_q, ovf_d;

  logic [SYM_W-1:0]  sh_q, sh_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;   // bits still to emit from sh_q
  logic              sof_q, sof_d;           // tag of the symbol in sh_q
  logic              x_out_q, x_out_d;
  logic              x_valid_q, x_valid_d;
  logic              x_sof_q, x_sof_d;

  logic              push, push_sof, pop, wr_en, fifo_empty, fifo_full;

  always_comb begin
    state_d     = state_q;
    sync_cnt_d  = sync_cnt_q;
    frame_cnt_d = frame_cnt_q;
    push        = 1'b0;
    push_sof    = 1'b0;

    // Framing FSM: only valid symbols move it.
    if (sym_valid) begin
      case (state_q)
        HUNT: begin
          if (sym_in == SYNC_WORD) begin
            if (sync_cnt_q == SYNC_LAST) begin
              state_d     = DATA;
              sync_cnt_d  = '0;
              frame_cnt_d = '0;
            end else begin
              sync_cnt_d = sync_cnt_q + SC_W'(1);
            end
          end else begin
            sync_cnt_d = '0;
          end
        end
        DATA: begin
          // Every data symbol is framed, SYNC_WORD values included.
          push     = 1'b1;
          push_sof = (frame_cnt_q == '0);
          if (frame_cnt_q == FRAME_LAST) begin
            state_d     = HUNT;
            sync_cnt_d  = '0;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + FC_W'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end
    locked_d = (state_d == DATA);

    // FIFO: a pop frees a slot in the same cycle, so push+pop while full
    // is accepted; a push into a full FIFO without a pop is dropped.
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == LVL_FULL);
    pop        = (bit_cnt_q <= BITS_ONE) && !fifo_empty;
    wr_en      = push && (!fifo_full || pop);
    ovf_d      = ovf_q | (push && fifo_full && !pop);
    level_d    = level_q + LW'(wr_en) - LW'(pop);
    wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;

    // Serialiser: emit sh_q[0] while bits remain; reload on the last bit
    // so the next symbol's bit0 follows without a gap.
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    sof_d     = sof_q;
    x_out_d   = 1'b0;
    x_valid_d = 1'b0;
    x_sof_d   = 1'b0;
    if (bit_cnt_q != '0) begin
      x_out_d   = sh_q[0];
      x_valid_d = 1'b1;
      x_sof_d   = sof_q && (bit_cnt_q == BITS_FULL);
      sh_d      = sh_q >> 1;
      bit_cnt_d = bit_cnt_q - BITS_ONE;
    end
    if (pop) begin
      {sof_d, sh_d} = fifo_mem[rd_ptr_q];
      bit_cnt_d     = BITS_FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HUNT;
      sync_cnt_q  <= '0;
      frame_cnt_q <= '0;
      locked_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ovf_q       <= 1'b0;
      sh_q        <= '0;
      bit_cnt_q   <= '0;
      sof_q       <= 1'b0;
      x_out_q     <= 1'b0;
      x_valid_q   <= 1'b0;
      x_sof_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_cnt_q  <= sync_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      locked_q    <= locked_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      ovf_q       <= ovf_d;
      sh_q        <= sh_d;
      bit_cnt_q   <= bit_cnt_d;
      sof_q       <= sof_d;
      x_out_q     <= x_out_d;
      x_valid_q   <= x_valid_d;
      x_sof_q     <= x_sof_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      fifo_mem[wr_ptr_q] <= {push_sof, sym_in};
    end
  end

  assign x_out      = x_out_q;
  assign x_valid    = x_valid_q;
  assign x_sof      = x_sof_q;
  assign locked     = locked_q;
  assign overflow   = ovf_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_ofdm_rx_deserializer.sv
// ---------------------------------------------------------------------------
// tb_ofdm_rx_deserializer
//   Two instances: index 0 uses FRAME_LEN=8 and index 1 uses FRAME_LEN=24.
//   A queue-based reference model predicts every output on every cycle.
//   Directed scenarios add stream-level expectations built from the symbol
//   lists, and a randomized phase follows them.
// ---------------------------------------------------------------------------
module tb_ofdm_rx_deserializer;
  localparam int SYM_W = 4;
  localparam int DEPTH = 16;
  localparam logic [3:0] SYNC = 4'h6;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sym_in;
  logic       sym_valid;
  logic       xo [2];
  logic       xv [2];
  logic       xs [2];
  logic       lk [2];
  logic       ov [2];
  logic [4:0] lvl [2];

  always #5 clk = ~clk;

  ofdm_rx_deserializer #(.FRAME_LEN(8)) dut (
    .clk(clk), .reset(reset), .sym_in(sym_in), .sym_valid(sym_valid),
    .x_out(xo[0]), .x_valid(xv[0]), .x_sof(xs[0]), .locked(lk[0]),
    .overflow(ov[0]), .fifo_level(lvl[0]));

  ofdm_rx_deserializer #(.FRAME_LEN(24)) dut24 (
    .clk(clk), .reset(reset), .sym_in(sym_in), .sym_valid(sym_valid),
    .x_out(xo[1]), .x_valid(xv[1]), .x_sof(xs[1]), .locked(lk[1]),
    .overflow(ov[1]), .fifo_level(lvl[1]));

  // Reference model state
  int         flen [2];
  logic       m_lock [2];
  int         m_sync [2];
  int         m_frame [2];
  logic [4:0] m_fq [2][$];
  logic [1:0] m_bq [2][$];
  logic       m_xo [2];
  logic       m_xv [2];
  logic       m_xs [2];
  logic       m_ovf [2];

  // Captured streams {sof, bit} and the cycle each bit appeared
  logic [1:0] got [2][$];
  int         got_cyc [2][$];
  logic [1:0] ref2 [$];
  int         cyc;
  int         checks;
  int         errors;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_edge(input int k);
    int pre;
    logic popped;
    logic [4:0] e;
    if (reset) begin
      m_lock[k] = 1'b0; m_sync[k] = 0; m_frame[k] = 0;
      m_fq[k].delete(); m_bq[k].delete();
      m_xo[k] = 1'b0; m_xv[k] = 1'b0; m_xs[k] = 1'b0; m_ovf[k] = 1'b0;
      return;
    end
    pre = m_fq[k].size();
    popped = 1'b0;
    if (m_bq[k].size() > 0) begin
      m_xo[k] = m_bq[k][0][0];
      m_xs[k] = m_bq[k][0][1];
      m_xv[k] = 1'b1;
      void'(m_bq[k].pop_front());
    end else begin
      m_xo[k] = 1'b0; m_xv[k] = 1'b0; m_xs[k] = 1'b0;
    end
    if (m_bq[k].size() == 0 && pre > 0) begin
      e = m_fq[k].pop_front();
      for (int b = 0; b < SYM_W; b++) m_bq[k].push_back({(b == 0) && e[4], e[b]});
      popped = 1'b1;
    end
    if (sym_valid) begin
      if (!m_lock[k]) begin
        if (sym_in == SYNC) begin
          m_sync[k]++;
          if (m_sync[k] == 2) begin
            m_lock[k] = 1'b1; m_frame[k] = 0; m_sync[k] = 0;
          end
        end else begin
          m_sync[k] = 0;
        end
      end else begin
        if (pre < DEPTH || popped) m_fq[k].push_back({m_frame[k] == 0, sym_in});
        else m_ovf[k] = 1'b1;
        m_frame[k]++;
        if (m_frame[k] == flen[k]) begin
          m_lock[k] = 1'b0; m_sync[k] = 0;
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic [3:0] s);
    sym_valid = v;
    sym_in = s;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k);
    cyc++;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("x_out", k, xo[k], m_xo[k]);
      chk("x_valid", k, xv[k], m_xv[k]);
      chk("x_sof", k, xs[k], m_xs[k]);
      chk("locked", k, lk[k], m_lock[k]);
      chk("overflow", k, ov[k], m_ovf[k]);
      chk("fifo_level", k, lvl[k], m_fq[k].size());
      if (xv[k]) begin
        got[k].push_back({xs[k], xo[k]});
        got_cyc[k].push_back(cyc);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 4'($urandom));
  endtask

  task automatic send_slow(input logic [3:0] s);
    step(1'b1, s);
    idle(3);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step(1'b1, 4'($urandom));
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      got[k].delete();
      got_cyc[k].delete();
    end
  endtask

  // Sync, then data 0x1..0x8 at one symbol per four clocks; checks the
  // lock edges and the LSB-first gapless stream of instance 0.
  task automatic run_s2();
    logic [3:0] d;
    send_slow(SYNC);
    chk("s2_lock_after_1st_sync", 0, lk[0], 0);
    send_slow(SYNC);
    chk("s2_lock_after_2nd_sync", 0, lk[0], 1);
    for (int i = 1; i <= 8; i++) begin
      send_slow(4'(i));
      chk("s2_lock_during_frame", i, lk[0], (i == 8) ? 0 : 1);
    end
    idle(12);
    chk("s2_stream_len", 0, got[0].size(), 32);
    if (got[0].size() == 32) begin
      for (int i = 1; i <= 8; i++) begin
        d = 4'(i);
        for (int b = 0; b < SYM_W; b++)
          chk("s2_stream_bit", (i - 1) * 4 + b, got[0][(i - 1) * 4 + b], {(i == 1) && (b == 0), d[b]});
      end
      chk("s2_gapless", 0, got_cyc[0][31] - got_cyc[0][0], 31);
    end
  endtask

  initial begin
    logic [3:0] data [24];
    int mx;
    int nsym;
    logic [3:0] v;
    flen[0] = 8;
    flen[1] = 24;
    checks = 0;
    errors = 0;
    cyc = 0;
    reset = 1'b1;
    sym_valid = 1'b0;
    sym_in = '0;

    // 1: reset held 10 cycles with sym_valid=1
    do_reset(10);
    for (int k = 0; k < 2; k++) begin
      chk("rst_x_out", k, xo[k], 0);
      chk("rst_x_valid", k, xv[k], 0);
      chk("rst_x_sof", k, xs[k], 0);
      chk("rst_locked", k, lk[k], 0);
      chk("rst_overflow", k, ov[k], 0);
      chk("rst_fifo_level", k, lvl[k], 0);
    end

    // 2: basic sync and frame
    run_s2();
    ref2 = got[0];

    // 3: false sync 6,3,6,6 then 0x9 as first data symbol
    do_reset(2);
    send_slow(SYNC);
    send_slow(4'h3);
    send_slow(SYNC);
    chk("s3_no_lock_yet", 0, lk[0], 0);
    send_slow(SYNC);
    chk("s3_locked", 0, lk[0], 1);
    send_slow(4'h9);
    for (int i = 0; i < 7; i++) send_slow(4'($urandom));
    idle(12);
    chk("s3_stream_len", 0, got[0].size(), 32);
    if (got[0].size() >= 4) begin
      chk("s3_first_bit0", 0, got[0][0], 2'b11);
      chk("s3_first_bit1", 0, got[0][1], 2'b00);
      chk("s3_first_bit2", 0, got[0][2], 2'b00);
      chk("s3_first_bit3", 0, got[0][3], 2'b01);
    end

    // 4: overflow on the FRAME_LEN=24 instance, 24 back-to-back symbols
    do_reset(2);
    send_slow(SYNC);
    send_slow(SYNC);
    mx = 0;
    for (int i = 0; i < 24; i++) begin
      data[i] = 4'($urandom);
      step(1'b1, data[i]);
      if (int'(lvl[1]) > mx) mx = lvl[1];
    end
    idle(100);
    chk("s4_level_peak", 1, mx, 16);
    chk("s4_overflow", 1, ov[1], 1);
    chk("s4_stream_whole_syms", 1, got[1].size() % 4, 0);
    nsym = got[1].size() / 4;
    chk("s4_some_dropped", 1, (nsym >= 16) && (nsym < 24), 1);
    if (nsym >= 16) begin
      chk("s4_sof_first", 1, got[1][0][1], 1);
      for (int i = 0; i < 16; i++) begin
        for (int b = 0; b < SYM_W; b++) v[b] = got[1][i * 4 + b][0];
        chk("s4_symbol", i, v, data[i]);
      end
    end

    // 5: sym_valid toggling during HUNT and DATA gives the scenario-2 stream
    do_reset(2);
    step(1'b1, SYNC); step(1'b0, SYNC);
    step(1'b1, SYNC); step(1'b0, 4'($urandom));
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 4'(i));
      step(1'b0, SYNC);
    end
    idle(40);
    chk("s5_stream_len", 0, got[0].size(), ref2.size());
    if (got[0].size() == ref2.size())
      for (int i = 0; i < ref2.size(); i++) chk("s5_stream_bit", i, got[0][i], ref2[i]);

    // 6: reset mid-frame with 5 symbols buffered, then scenario 2 again
    do_reset(2);
    step(1'b1, SYNC);
    step(1'b1, SYNC);
    for (int i = 0; i < 7; i++) step(1'b1, 4'($urandom));
    chk("s6_buffered", 0, lvl[0], 5);
    reset = 1'b1;
    step(1'b1, SYNC);
    reset = 1'b0;
    chk("s6_rst_x_valid", 0, xv[0], 0);
    chk("s6_rst_x_out", 0, xo[0], 0);
    chk("s6_rst_locked", 0, lk[0], 0);
    chk("s6_rst_level", 0, lvl[0], 0);
    chk("s6_rst_overflow", 1, ov[1], 0);
    for (int k = 0; k < 2; k++) begin
      got[k].delete();
      got_cyc[k].delete();
    end
    run_s2();
    chk("s6_same_as_s2_len", 0, got[0].size(), ref2.size());
    if (got[0].size() == ref2.size())
      for (int i = 0; i < ref2.size(); i++) chk("s6_same_as_s2", i, got[0][i], ref2[i]);

    // Randomized phase against the model
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      step($urandom_range(0, 3) != 0, ($urandom_range(0, 2) == 0) ? SYNC : 4'($urandom));
    end
    reset = 1'b0;
    idle(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
